// File: rtl/scp_program_loader.sv
// rtl/scp_program_loader.sv - byte-serial loader writing framed words into instruction/data memory
// Holds the core in reset while loading; releases it only after a frame's checksum matches.
module scp_program_loader #(
  parameter int MAX_WORDS = 1024,
  parameter int TIMEOUT   = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic        mem_sel,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic        core_rstb,
  output logic        done,
  output logic        err,
  output logic [2:0]  err_code
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_TGT   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_CNT   = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_CSUM  = 3'd6;

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]    state;
  logic [1:0]    bcnt;
  logic [15:0]   remain;
  logic [7:0]    csum;
  logic [TW-1:0] idle_cnt;

  logic          accept;
  logic          timing;
  logic          timed_out;
  logic          fail;
  logic [2:0]    fail_code;
  logic [31:0]   addr_next;
  logic [15:0]   cnt_next;

  assign in_ready  = (state != S_WRITE);
  assign mem_we    = (state == S_WRITE);
  assign accept    = in_valid && in_ready;
  assign timing    = (state inside {S_TGT, S_ADDR, S_CNT, S_DATA, S_CSUM});
  assign timed_out = timing && !accept && (idle_cnt == TW'(TIMEOUT - 1));
  // Multi-byte fields arrive little-endian, so each new byte shifts in from the top.
  assign addr_next = {in_data, mem_addr[31:8]};
  assign cnt_next  = {in_data, remain[15:8]};

  always_comb begin
    fail      = 1'b0;
    fail_code = 3'd0;
    if (timed_out) begin
      fail      = 1'b1;
      fail_code = 3'd5;
    end else if (accept) begin
      case (state)
        S_TGT:  if (in_data > 8'd1) begin
                  fail = 1'b1; fail_code = 3'd1;
                end
        S_ADDR: if (bcnt == 2'd3 && addr_next[1:0] != 2'd0) begin
                  fail = 1'b1; fail_code = 3'd2;
                end
        S_CNT:  if (bcnt == 2'd1 && 32'(cnt_next) > MAX_WORDS) begin
                  fail = 1'b1; fail_code = 3'd3;
                end
        S_CSUM: if (in_data != csum) begin
                  fail = 1'b1; fail_code = 3'd4;
                end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bcnt      <= 2'd0;
      remain    <= 16'd0;
      csum      <= 8'd0;
      idle_cnt  <= '0;
      mem_sel   <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      core_rstb <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 3'd0;
    end else begin
      if (timing && !accept) idle_cnt <= idle_cnt + 1'b1;
      else                   idle_cnt <= '0;

      if (accept && state != S_IDLE && state != S_CSUM) csum <= csum + in_data;

      if (fail) begin
        state    <= S_IDLE;
        err      <= 1'b1;
        err_code <= fail_code;
      end else begin
        case (state)
          S_IDLE: if (accept && in_data == 8'hA5) begin
            state     <= S_TGT;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 3'd0;
            core_rstb <= 1'b0;
            csum      <= 8'd0;
            bcnt      <= 2'd0;
          end
          S_TGT: if (accept) begin
            mem_sel <= in_data[0];
            state   <= S_ADDR;
          end
          S_ADDR: if (accept) begin
            mem_addr <= addr_next;
            bcnt     <= bcnt + 2'd1;
            if (bcnt == 2'd3) state <= S_CNT;
          end
          S_CNT: if (accept) begin
            remain <= cnt_next;
            bcnt   <= bcnt + 2'd1;
            if (bcnt == 2'd1) begin
              bcnt  <= 2'd0;
              state <= (cnt_next == 16'd0) ? S_CSUM : S_DATA;
            end
          end
          S_DATA: if (accept) begin
            mem_wdata <= {in_data, mem_wdata[31:8]};
            bcnt      <= bcnt + 2'd1;
            if (bcnt == 2'd3) state <= S_WRITE;
          end
          S_WRITE: if (mem_ready) begin
            mem_addr <= mem_addr + 32'd4;
            remain   <= remain - 16'd1;
            state    <= (remain == 16'd1) ? S_CSUM : S_DATA;
          end
          S_CSUM: if (accept) begin
            done      <= 1'b1;
            core_rstb <= 1'b1;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scp_program_loader.sv
// tb/tb_scp_program_loader.sv - randomized self-checking bench for scp_program_loader
module tb_scp_program_loader;

  localparam int MAXW = 1024;
  localparam int TO   = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_ready;
  logic        mem_we;
  logic        mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b1;
  logic        core_rstb;
  logic        done;
  logic        err;
  logic [2:0]  err_code;

  always #5 clk = ~clk;

  scp_program_loader #(.MAX_WORDS(MAXW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .core_rstb(core_rstb), .done(done), .err(err), .err_code(err_code)
  );

  int total = 0;
  int bad   = 0;

  logic        exp_sel[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [7:0]  fq[$];
  logic [7:0]  fsum;

  int          rdy_mode = 0;
  int          wr_idx   = 0;
  int          stalls   = 0;
  logic        held = 1'b0;
  logic [31:0] held_addr, held_data;

  // One clock: pick mem_ready, check any write landing this edge, advance to the next negedge.
  task automatic step();
    logic        es;
    logic [31:0] ea, ed;
    if (rdy_mode == 2)      mem_ready = !(mem_we && wr_idx == 1 && stalls < 3);
    else if (rdy_mode == 1) mem_ready = 1'($urandom_range(0, 1));
    else                    mem_ready = 1'b1;
    if (!rst && held && mem_we) begin
      total++;
      if (mem_addr !== held_addr || mem_wdata !== held_data || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL write_hold addr=%h want %h data=%h want %h in_ready=%b want 0",
                 mem_addr, held_addr, mem_wdata, held_data, in_ready);
      end
    end
    held = 1'b0;
    if (!rst && mem_we && !mem_ready) begin
      held = 1'b1; held_addr = mem_addr; held_data = mem_wdata; stalls++;
    end
    if (!rst && mem_we && mem_ready) begin
      total++;
      if (exp_addr.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write sel=%b addr=%h data=%h", mem_sel, mem_addr, mem_wdata);
      end else begin
        es = exp_sel.pop_front(); ea = exp_addr.pop_front(); ed = exp_data.pop_front();
        if (mem_sel !== es || mem_addr !== ea || mem_wdata !== ed) begin
          bad++;
          $display("FAIL write got sel=%b addr=%h data=%h want sel=%b addr=%h data=%h",
                   mem_sel, mem_addr, mem_wdata, es, ea, ed);
        end
      end
      wr_idx++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    do begin
      acc = in_ready;
      step();
      n++;
    end while (!acc && n < 200);
    in_valid = 1'b0;
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL send_byte byte %h not accepted within %0d cycles", b, n);
    end
  endtask

  task automatic send_range(input int first, input int last, input int gap);
    for (int i = first; i <= last; i++) begin
      send_byte(fq[i]);
      repeat ($urandom_range(0, gap)) step();
    end
  endtask

  function automatic void put(input logic [7:0] b);
    fq.push_back(b);
    fsum = fsum + b;
  endfunction

  // Reference model: frame bytes from the field values, plus the writes and error code they imply.
  task automatic make_frame(input logic [7:0] tgt, input logic [31:0] addr, input int n,
                            input bit bad_csum, output logic [2:0] code);
    logic [31:0] w;
    fq.delete();
    fq.push_back(8'hA5);
    fsum = 8'd0;
    code = 3'd0;
    put(tgt);
    if (tgt > 8'd1) begin code = 3'd1; return; end
    for (int i = 0; i < 4; i++) put(addr[8*i +: 8]);
    if (addr[1:0] != 2'd0) begin code = 3'd2; return; end
    put(n[7:0]);
    put(n[15:8]);
    if (n > MAXW) begin code = 3'd3; return; end
    for (int k = 0; k < n; k++) begin
      w = $urandom;
      for (int i = 0; i < 4; i++) put(w[8*i +: 8]);
      exp_sel.push_back(tgt[0]);
      exp_addr.push_back(addr + 32'(4 * k));
      exp_data.push_back(w);
    end
    fq.push_back(bad_csum ? fsum + 8'd1 : fsum);
    code = bad_csum ? 3'd4 : 3'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    total++;
    if ({in_ready, mem_we, mem_sel, mem_addr, mem_wdata, core_rstb, done, err, err_code} !==
        {1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL reset_state rdy=%b we=%b sel=%b addr=%h wd=%h rstb=%b done=%b err=%b code=%0d",
               in_ready, mem_we, mem_sel, mem_addr, mem_wdata, core_rstb, done, err, err_code);
    end
  endtask

  task automatic test_basic(input logic [7:0] csum_byte, input bit expect_ok);
    fq = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h01, 8'h00,
           8'h13, 8'h00, 8'h00, 8'h20, 8'h74};
    fq[12] = csum_byte;
    rdy_mode = 0;
    exp_sel.push_back(1'b0); exp_addr.push_back(32'h0040_0000); exp_data.push_back(32'h2000_0013);
    send_range(0, 12, 0);
    total++;
    if (exp_addr.size() != 0) begin
      bad++; $display("FAIL basic_write_missing remaining=%0d want 0", exp_addr.size());
    end
    total++;
    if (expect_ok && {done, err, err_code, core_rstb} !== {1'b1, 1'b0, 3'd0, 1'b1}) begin
      bad++; $display("FAIL basic_ok done=%b err=%b code=%0d rstb=%b want 1 0 0 1", done, err, err_code, core_rstb);
    end else if (!expect_ok && {done, err, err_code, core_rstb} !== {1'b0, 1'b1, 3'd4, 1'b0}) begin
      bad++; $display("FAIL basic_csum done=%b err=%b code=%0d rstb=%b want 0 1 4 0", done, err, err_code, core_rstb);
    end
  endtask

  task automatic test_stall();
    logic [2:0] code;
    rdy_mode = 2; wr_idx = 0; stalls = 0;
    make_frame(8'd1, 32'h1000_0000, 3, 1'b0, code);
    send_range(0, fq.size() - 1, 1);
    total++;
    if (stalls != 3 || exp_addr.size() != 0) begin
      bad++; $display("FAIL stall_count stalls=%0d want 3 pending=%0d want 0", stalls, exp_addr.size());
    end
    total++;
    if ({done, err, core_rstb} !== {1'b1, 1'b0, 1'b1}) begin
      bad++; $display("FAIL stall_done done=%b err=%b rstb=%b want 1 0 1", done, err, core_rstb);
    end
    rdy_mode = 0;
  endtask

  task automatic test_garbage();
    logic [2:0] code;
    send_byte(8'h00);
    send_byte(8'hFF);
    total++;
    if ({done, err, core_rstb} !== {1'b1, 1'b0, 1'b1}) begin
      bad++; $display("FAIL garbage_dropped done=%b err=%b rstb=%b want 1 0 1", done, err, core_rstb);
    end
    send_byte(8'hA5);
    send_byte(8'h02);
    total++;
    if ({done, err, err_code, core_rstb} !== {1'b0, 1'b1, 3'd1, 1'b0}) begin
      bad++; $display("FAIL bad_target done=%b err=%b code=%0d rstb=%b want 0 1 1 0", done, err, err_code, core_rstb);
    end
    make_frame(8'd0, {$urandom} & ~32'd3, 2, 1'b0, code);
    send_range(0, fq.size() - 1, 0);
    total++;
    if ({done, err, err_code, core_rstb} !== {1'b1, 1'b0, 3'd0, 1'b1} || exp_addr.size() != 0) begin
      bad++; $display("FAIL recover done=%b err=%b code=%0d rstb=%b want 1 0 0 1", done, err, err_code, core_rstb);
    end
  endtask

  task automatic test_errors();
    logic [2:0] code;
    int w0;
    bit seen;
    w0 = wr_idx;
    make_frame(8'd0, 32'h0040_0002, 1, 1'b0, code);
    send_range(0, fq.size() - 1, 0);
    total++;
    if ({err, err_code, done} !== {1'b1, 3'd2, 1'b0}) begin
      bad++; $display("FAIL misaligned err=%b code=%0d done=%b want 1 2 0", err, err_code, done);
    end
    make_frame(8'd1, 32'h0000_2000, MAXW + 1, 1'b0, code);
    send_range(0, fq.size() - 1, 0);
    total++;
    if ({err, err_code, done} !== {1'b1, 3'd3, 1'b0}) begin
      bad++; $display("FAIL count_max err=%b code=%0d done=%b want 1 3 0", err, err_code, done);
    end
    make_frame(8'd0, 32'h0000_0100, 2, 1'b0, code);
    exp_sel.delete(); exp_addr.delete(); exp_data.delete();
    send_range(0, 7, 0);
    repeat (TO - 2) step();
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL timeout_early err=%b want 0 after %0d idle cycles", err, TO - 2);
    end
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      step();
      seen = (err === 1'b1);
    end
    total++;
    if (!seen || err_code !== 3'd5) begin
      bad++; $display("FAIL timeout err=%b code=%0d want 1 5", err, err_code);
    end
    total++;
    if (wr_idx != w0) begin
      bad++; $display("FAIL error_writes writes=%0d want 0", wr_idx - w0);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] code;
    int w0;
    w0 = wr_idx;
    make_frame(8'd1, 32'h1000_0100, 4, 1'b0, code);
    send_range(0, 13, 0);
    exp_sel.delete(); exp_addr.delete(); exp_data.delete();
    total++;
    if (wr_idx != w0 + 1) begin
      bad++; $display("FAIL mid_first_write writes=%0d want 1", wr_idx - w0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({in_ready, mem_we, mem_sel, mem_addr, mem_wdata, core_rstb, done, err, err_code} !==
        {1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL mid_reset rdy=%b we=%b sel=%b addr=%h wd=%h rstb=%b done=%b err=%b code=%0d",
               in_ready, mem_we, mem_sel, mem_addr, mem_wdata, core_rstb, done, err, err_code);
    end
    make_frame(8'd0, 32'h0000_0400, 4, 1'b0, code);
    send_range(0, fq.size() - 1, 0);
    total++;
    if ({done, err, core_rstb} !== {1'b1, 1'b0, 1'b1} || exp_addr.size() != 0) begin
      bad++; $display("FAIL mid_reload done=%b err=%b rstb=%b pending=%0d want 1 0 1 0",
                      done, err, core_rstb, exp_addr.size());
    end
  endtask

  task automatic test_random();
    logic [2:0]  code;
    logic [7:0]  tgt, junk;
    logic [31:0] addr;
    int          n;
    rdy_mode = 1;
    for (int it = 0; it < 12; it++) begin
      junk = 8'($urandom_range(0, 254));
      if (junk == 8'hA5) junk = 8'h5A;
      send_byte(junk);
      tgt  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1));
      addr = $urandom & ~32'd3;
      if ($urandom_range(0, 7) == 0) addr = addr | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 5) == 0) addr = 32'hFFFF_FFF8;
      n = ($urandom_range(0, 9) == 0) ? MAXW + 1 + $urandom_range(0, 100) : $urandom_range(0, 4);
      make_frame(tgt, addr, n, $urandom_range(0, 4) == 0, code);
      send_range(0, fq.size() - 1, 2);
      total++;
      if ({err_code, err, done, core_rstb} !== {code, code != 3'd0, code == 3'd0, code == 3'd0}
          || exp_addr.size() != 0) begin
        bad++;
        $display("FAIL random[%0d] code=%0d err=%b done=%b rstb=%b want code=%0d pending=%0d",
                 it, err_code, err, done, core_rstb, code, exp_addr.size());
        exp_sel.delete(); exp_addr.delete(); exp_data.delete();
      end
    end
    rdy_mode = 0;
  endtask

  initial begin
    test_reset();
    test_basic(8'h74, 1'b1);
    test_basic(8'h75, 1'b0);
    test_stall();
    test_garbage();
    test_errors();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
